// File: rtl/pll_reset_sequencer.sv
// Sequences the rPLL reset, qualifies lock and releases downstream reset.
// Repeated lock failures latch a fault.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 27,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int STABLE_CYCLES  = 2700,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk27mhz,
    input  logic       rst,
    input  logic       lock_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic             lock_m, lock_s;

    always_ff @(posedge clk27mhz or negedge rst) begin
        if (!rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock_i;
            lock_s <= lock_m;
        end
    end

    // A lock edge on the timeout/completion cycle takes priority over the count.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt_o;
        loss_nxt  = loss_cnt_o;
        case (state)
            PLL_RST: begin
                if (cnt == CNT_W'(PLL_RST_CYCLES - 1))
                    state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt_o == 4'(MAX_RETRIES)) begin
                        state_nxt = FAULT;
                    end else begin
                        retry_nxt = retry_cnt_o + 4'd1;
                        state_nxt = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                    retry_nxt = 4'd0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                    if (loss_cnt_o != 8'hFF)
                        loss_nxt = loss_cnt_o + 8'd1;
                end
            end
            FAULT: ;
            default: state_nxt = PLL_RST;
        endcase
    end

    always_ff @(posedge clk27mhz or negedge rst) begin
        if (!rst) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_reset_o <= 1'b1;
            sys_rst_n_o <= 1'b0;
            ready_o     <= 1'b0;
            fault_o     <= 1'b0;
            retry_cnt_o <= 4'd0;
            loss_cnt_o  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state != RUN && state != FAULT)
                cnt <= cnt + 1'b1;
            // Outputs follow the next state so they switch with the state register.
            pll_reset_o <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
            sys_rst_n_o <= (state_nxt == RUN);
            ready_o     <= (state_nxt == RUN);
            fault_o     <= (state_nxt == FAULT);
            retry_cnt_o <= retry_nxt;
            loss_cnt_o  <= loss_nxt;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

    logic       clk27mhz = 1'b0;
    logic       rst = 1'b1;
    logic       lock_i = 1'b0;
    logic       pll_reset_o, sys_rst_n_o, ready_o, fault_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    int n_chk = 0;
    int n_pass = 0;
    int ecnt = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3)
    ) dut (
        .clk27mhz   (clk27mhz),
        .rst        (rst),
        .lock_i     (lock_i),
        .pll_reset_o(pll_reset_o),
        .sys_rst_n_o(sys_rst_n_o),
        .ready_o    (ready_o),
        .fault_o    (fault_o),
        .retry_cnt_o(retry_cnt_o),
        .loss_cnt_o (loss_cnt_o)
    );

    always #5 clk27mhz = ~clk27mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
    endtask

    task automatic tick();
        @(posedge clk27mhz);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int e);
        while (ecnt < e) tick();
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_pll"},   32'(pll_reset_o), 1);
        chk({tag, "_sys"},   32'(sys_rst_n_o), 0);
        chk({tag, "_ready"}, 32'(ready_o),     0);
        chk({tag, "_fault"}, 32'(fault_o),     0);
        chk({tag, "_retry"}, 32'(retry_cnt_o), 0);
        chk({tag, "_loss"},  32'(loss_cnt_o),  0);
    endtask

    task automatic do_reset(input string tag);
        lock_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_rst(tag);
        repeat (2) @(posedge clk27mhz);
        @(negedge clk27mhz);
        rst = 1'b1;
        ecnt = 0;
    endtask

    initial begin
        int rises, highs, to_cnt, waited;
        logic prev;
        #2;

        // Normal start: L=14, release at L+10
        do_reset("rst0");
        run_to(3);  chk("t1_pll_e3", 32'(pll_reset_o), 1);
        run_to(4);  chk("t1_pll_e4", 32'(pll_reset_o), 0);
        run_to(13); lock_i = 1'b1;
        run_to(23); chk("t1_sys_e23", 32'(sys_rst_n_o), 0);
        run_to(24);
        chk("t1_sys_e24",   32'(sys_rst_n_o), 1);
        chk("t1_ready_e24", 32'(ready_o),     1);
        chk("t1_retry",     32'(retry_cnt_o), 0);
        chk("t1_fault",     32'(fault_o),     0);

        // Chatter: lock_s drops exactly on the completion cycle (edge 24)
        do_reset("rst1");
        run_to(13); lock_i = 1'b1;
        run_to(21); lock_i = 1'b0;
        run_to(24); chk("t2_sys_e24", 32'(sys_rst_n_o), 0);
        lock_i = 1'b1;
        highs = 0;
        while (ecnt < 34) begin
            tick();
            if (pll_reset_o) highs++;
        end
        chk("t2_pll_low", 32'(highs), 0);
        chk("t2_sys_e34", 32'(sys_rst_n_o), 0);
        run_to(35);
        chk("t2_sys_e35", 32'(sys_rst_n_o), 1);
        chk("t2_retry",   32'(retry_cnt_o), 0);

        // Timeouts to fault: pulses start at edges 0,24,48,72; fault at 96
        do_reset("rst2");
        rises = 0; highs = 0; prev = pll_reset_o;
        while (ecnt < 95) begin
            tick();
            if (pll_reset_o && !prev) rises++;
            if (pll_reset_o) highs++;
            prev = pll_reset_o;
        end
        chk("t3_rises",     32'(rises),       3);
        chk("t3_highs",     32'(highs),       15);
        chk("t3_retry_e95", 32'(retry_cnt_o), 3);
        chk("t3_fault_e95", 32'(fault_o),     0);
        run_to(96);
        chk("t3_fault_e96", 32'(fault_o),     1);
        chk("t3_pll_e96",   32'(pll_reset_o), 1);
        chk("t3_retry_e96", 32'(retry_cnt_o), 3);
        run_to(130);
        chk("t3_fault_hold", 32'(fault_o),     1);
        chk("t3_pll_hold",   32'(pll_reset_o), 1);
        chk("t3_sys_hold",   32'(sys_rst_n_o), 0);

        // Recovery on third attempt: L=56, STABLE at 58, RUN at 66
        do_reset("rst3");
        run_to(55); lock_i = 1'b1;
        run_to(58);
        chk("t4_retry_e58", 32'(retry_cnt_o), 2);
        chk("t4_pll_e58",   32'(pll_reset_o), 0);
        run_to(65);
        chk("t4_ready_e65", 32'(ready_o),     0);
        chk("t4_retry_e65", 32'(retry_cnt_o), 2);
        run_to(66);
        chk("t4_ready_e66", 32'(ready_o),     1);
        chk("t4_sys_e66",   32'(sys_rst_n_o), 1);
        chk("t4_retry_e66", 32'(retry_cnt_o), 0);

        // Lock loss in RUN: F=70
        run_to(69); lock_i = 1'b0;
        run_to(71); chk("t5_sys_e71", 32'(sys_rst_n_o), 1);
        run_to(72);
        chk("t5_sys_e72",   32'(sys_rst_n_o), 0);
        chk("t5_ready_e72", 32'(ready_o),     0);
        chk("t5_pll_e72",   32'(pll_reset_o), 1);
        chk("t5_loss_e72",  32'(loss_cnt_o),  1);
        run_to(77); lock_i = 1'b1;
        run_to(87); chk("t5_ready_e87", 32'(ready_o), 0);
        run_to(88);
        chk("t5_ready_e88", 32'(ready_o),    1);
        chk("t5_loss_e88",  32'(loss_cnt_o), 1);

        // Losses 2..300, saturating at 255
        to_cnt = 0;
        for (int i = 2; i <= 300; i++) begin
            lock_i = 1'b0;
            repeat (3) tick();
            lock_i = 1'b1;
            waited = 0;
            while (!ready_o && waited < 40) begin
                tick();
                waited++;
            end
            if (!ready_o) to_cnt++;
            if (i == 254) chk("t5_loss_254", 32'(loss_cnt_o), 254);
            if (i == 256) chk("t5_loss_256", 32'(loss_cnt_o), 255);
        end
        chk("t5_relock_timeouts", 32'(to_cnt),     0);
        chk("t5_loss_300",        32'(loss_cnt_o), 255);

        // Async reset mid-STABLE (STABLE entered 16, count 3 after edge 19)
        do_reset("rst4");
        run_to(13); lock_i = 1'b1;
        run_to(19);
        chk("t6_pll_pre", 32'(pll_reset_o), 0);
        #2;
        rst = 1'b0;
        #1;
        chk_rst("t6_async");
        @(negedge clk27mhz);
        rst = 1'b1;
        ecnt = 0;
        run_to(3);  chk("t6_pll_e3",    32'(pll_reset_o), 1);
        run_to(4);  chk("t6_pll_e4",    32'(pll_reset_o), 0);
        run_to(12); chk("t6_ready_e12", 32'(ready_o),     0);
        run_to(13); chk("t6_ready_e13", 32'(ready_o),     1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
